rvvi_host_throttle: RTL and testbench

Generates host-directed stall windows for the RVVI trace Ethernet path. It is the parametrised successor to the single-source slow-down generator and sits between the host-request decode and the RVVI frame packer.
- Accepts slow-down requests from NUM_SRC independent sources.
- Queues overlapping requests in a saturating pending counter.
- Sizes each stall window either as a fixed length or adaptively from the host FIFO fill level.
- Enforces a minimum gap between consecutive windows.

---
 rtl/rvvi_host_throttle_pkg.sv | 16 +
 rtl/rvvi_throttle_holdlen.sv | 29 ++
 rtl/rvvi_host_throttle.sv | 164 ++++++++++++++++
 tb/tb_rvvi_host_throttle.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rvvi_host_throttle_pkg.sv
// Shared definitions for the RVVI host throttle: FSM state encoding and the
// position of the fill-level byte within HostFiFoFillAmt.
package rvvi_host_throttle_pkg;

  typedef enum logic [1:0] {
    THR_IDLE,
    THR_ARM,
    THR_HOLD,
    THR_GAP
  } thr_state_e;

  localparam int unsigned FILL_MSB = 31;
  localparam int unsigned FILL_LSB = 24;
  localparam int unsigned FILL_W   = FILL_MSB - FILL_LSB + 1;

endpackage

// File: rtl/rvvi_throttle_holdlen.sv
// Combinational stall-window length: BASE_HOLD in fixed mode, or BASE_HOLD
// shifted by min(msb_index(fill)+1, MAX_SHIFT) in adaptive mode (shift 0 when
// the fill byte is zero).
module rvvi_throttle_holdlen
  import rvvi_host_throttle_pkg::*;
#(
  parameter int unsigned BASE_HOLD = 4000,
  parameter int unsigned MAX_SHIFT = 4,
  parameter int unsigned CNT_W     = 17
) (
  input  logic [FILL_W-1:0] fill_byte,
  input  logic              adaptive,
  output logic [CNT_W-1:0]  hold_len
);

  logic [3:0] shift;

  // Highest set bit wins; clamp to MAX_SHIFT and force zero in fixed mode
  always_comb begin
    shift = '0;
    for (int unsigned i = 0; i < FILL_W; i++) begin
      if (fill_byte[i]) shift = 4'(i + 1);
    end
    if (32'(shift) > MAX_SHIFT) shift = 4'(MAX_SHIFT);
    if (!adaptive) shift = '0;
    hold_len = CNT_W'(BASE_HOLD) << shift;
  end

endmodule

// File: rtl/rvvi_host_throttle.sv
// Host-directed stall window generator for the RVVI trace Ethernet path.
// Counts rising edges of NUM_SRC slow-down requests into a saturating pending
// counter and serves them one window at a time: wait for a frame boundary,
// hold HostStall for a fixed or fill-scaled length, then idle for GAP_CYCLES.
// Optional macro RVVI_THROTTLE_STATS_EN adds StallCycles/WindowCount outputs.
module rvvi_host_throttle
  import rvvi_host_throttle_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned BASE_HOLD  = 4000,
  parameter int unsigned MAX_SHIFT  = 4,
  parameter int unsigned CNT_W      = 17,
  parameter int unsigned PEND_W     = 10,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_SRC-1:0] HostRequestSlowDown,
  input  logic               RVVIStall,
  input  logic [31:0]        HostFiFoFillAmt,
  input  logic               AdaptiveMode,
  output logic               HostStall,
  output logic [PEND_W-1:0]  PendingCount,
  output logic               Overflow
`ifdef RVVI_THROTTLE_STATS_EN
  ,
  output logic [31:0]        StallCycles,
  output logic [15:0]        WindowCount
`endif
);

  localparam int unsigned SUM_W = PEND_W + 4;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [SUM_W-1:0] PEND_MAX = {4'b0000, {PEND_W{1'b1}}};

  thr_state_e         state, next_state;
  logic [NUM_SRC-1:0] req_prev;
  logic [NUM_SRC-1:0] edges;
  logic [3:0]         new_reqs;
  logic [CNT_W-1:0]   hold_len;
  logic [CNT_W-1:0]   hold_len_q;
  logic [CNT_W-1:0]   hold_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               hold_last;
  logic               arm_to_hold;
  logic               take_req;
  logic [SUM_W-1:0]   pend_sum;
  logic [PEND_W-1:0]  pend_next;
  logic               ovf_set;
  logic               unused_fill_bits;

  assign unused_fill_bits = ^HostFiFoFillAmt[FILL_LSB-1:0];

  rvvi_throttle_holdlen #(
    .BASE_HOLD (BASE_HOLD),
    .MAX_SHIFT (MAX_SHIFT),
    .CNT_W     (CNT_W)
  ) u_holdlen (
    .fill_byte (HostFiFoFillAmt[FILL_MSB:FILL_LSB]),
    .adaptive  (AdaptiveMode),
    .hold_len  (hold_len)
  );

  // Previous request levels for rising-edge detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) req_prev <= '0;
    else         req_prev <= HostRequestSlowDown;
  end

  // Rising edges and their population count
  always_comb begin
    edges    = HostRequestSlowDown & ~req_prev;
    new_reqs = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      new_reqs = new_reqs + 4'(edges[i]);
    end
  end

  assign hold_last   = (hold_cnt == hold_len_q - CNT_W'(1));
  assign arm_to_hold = (state == THR_ARM) && RVVIStall;
  assign take_req    = (state == THR_IDLE) && ((new_reqs != '0) || (PendingCount != '0));

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= THR_IDLE;
    else         state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      THR_IDLE: if (take_req) next_state = THR_ARM;
      THR_ARM:  if (RVVIStall) next_state = THR_HOLD;
      THR_HOLD: if (hold_last) next_state = (GAP_CYCLES == 0) ? THR_IDLE : THR_GAP;
      THR_GAP:  if (gap_cnt == GAP_LAST) next_state = THR_IDLE;
      default:  next_state = THR_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    HostStall = (state == THR_HOLD);
  end

  // Hold counter and window length latched at the frame boundary
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_cnt   <= '0;
      hold_len_q <= '0;
    end else if (arm_to_hold) begin
      hold_cnt   <= '0;
      hold_len_q <= hold_len;
    end else if (state == THR_HOLD) begin
      hold_cnt   <= hold_cnt + CNT_W'(1);
    end
  end

  // Gap counter, restarted throughout HOLD so GAP always begins at zero
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                 gap_cnt <= '0;
    else if (state == THR_HOLD)  gap_cnt <= '0;
    else if (state == THR_GAP)   gap_cnt <= gap_cnt + GAP_W'(1);
  end

  // Serving a request from IDLE nets to pend+new-1 whether the request came
  // from the queue or from an edge in the same cycle
  always_comb begin
    pend_sum = SUM_W'(PendingCount) + SUM_W'(new_reqs);
    if (take_req) pend_sum = pend_sum - SUM_W'(1);
    ovf_set   = 1'b0;
    pend_next = pend_sum[PEND_W-1:0];
    if (pend_sum > PEND_MAX) begin
      pend_next = '1;
      ovf_set   = 1'b1;
    end
  end

  // Pending counter and sticky overflow flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      PendingCount <= '0;
      Overflow     <= 1'b0;
    end else begin
      PendingCount <= pend_next;
      if (ovf_set) Overflow <= 1'b1;
    end
  end

`ifdef RVVI_THROTTLE_STATS_EN
  // Saturating stall-cycle and window counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      StallCycles <= '0;
      WindowCount <= '0;
    end else begin
      if ((state == THR_HOLD) && (StallCycles != '1)) StallCycles <= StallCycles + 32'd1;
      if (arm_to_hold && (WindowCount != '1))         WindowCount <= WindowCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rvvi_host_throttle.sv
// Self-checking bench for rvvi_host_throttle with small window/gap sizes.
module tb_rvvi_host_throttle;

  localparam int unsigned BASE = 20;
  localparam int unsigned MAXS = 4;
  localparam int unsigned PW   = 2;
  localparam int unsigned GAP  = 5;
  localparam int unsigned PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic [1:0]    req;
  logic          rvvi;
  logic [31:0]   fill;
  logic          mode;
  logic          host_stall;
  logic [PW-1:0] pend;
  logic          ovf;
`ifdef RVVI_THROTTLE_STATS_EN
  logic [31:0]   stall_cycles;
  logic [15:0]   window_count;
`endif

  int checks = 0;
  int errors = 0;

  rvvi_host_throttle #(
    .NUM_SRC    (2),
    .BASE_HOLD  (BASE),
    .MAX_SHIFT  (MAXS),
    .CNT_W      (10),
    .PEND_W     (PW),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .HostRequestSlowDown (req),
    .RVVIStall           (rvvi),
    .HostFiFoFillAmt     (fill),
    .AdaptiveMode        (mode),
    .HostStall           (host_stall),
    .PendingCount        (pend),
    .Overflow            (ovf)
`ifdef RVVI_THROTTLE_STATS_EN
    ,
    .StallCycles         (stall_cycles),
    .WindowCount         (window_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference window length straight from the sizing rule
  function automatic int unsigned exp_hold(input logic adaptive, input logic [7:0] b);
    int unsigned s = 0;
    if (!adaptive) return BASE;
    for (int k = 0; k < 8; k++) if (b[k]) s = k + 1;
    if (s > MAXS) s = MAXS;
    return BASE * (1 << s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] m);
    req = m;
    step();
    req = '0;
    step();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    step();
  endtask

  // Low cycles before the next window, then its length; mut perturbs fill/mode mid-window
  task automatic measure(output int len, output int low, input bit mut);
    low = 0;
    while (!host_stall && low < 1000) begin low++; step(); end
    len = 0;
    while (host_stall && len < 2000) begin
      if (mut && len == 3) begin
        fill = $urandom;
        mode = ~mode;
      end
      len++;
      step();
    end
  endtask

  initial begin
    int len, low, total, n;
    bit rose;
    logic [7:0] b;
    logic [1:0] m;

    resetn = 1'b0; req = '0; rvvi = 1'b0; fill = '0; mode = 1'b0;
    repeat (3) step();
    check("reset_stall", host_stall, 0);
    check("reset_pend", pend, 0);
    check("reset_ovf", ovf, 0);
    resetn = 1'b1;
    step();

    // Fixed mode, RVVIStall arrives a few cycles after the request
    fill = $urandom | 32'hFF00_0000;
    pulse(2'b01);
    step();
    rvvi = 1'b1;
    measure(len, low, 1'b0);
    check("fixed_len", len, BASE);
    check("fixed_pend", pend, 0);
    rose = 1'b0;
    repeat (GAP + 10) begin if (host_stall) rose = 1'b1; step(); end
    check("fixed_quiet", rose, 0);

    // Adaptive sizing with boundary fills, then random fills with mid-window changes
    for (int i = 0; i < 6; i++) begin
      b = (i == 0) ? 8'h00 : (i == 1) ? 8'h05 : (i == 2) ? 8'hFF : 8'($urandom);
      mode = 1'b1;
      fill = {b, 24'($urandom)};
      pulse(2'b01);
      measure(len, low, i >= 2);
      check($sformatf("adapt_len_%02x", b), len, exp_hold(1'b1, b));
      mode = 1'b1;
      repeat (GAP + 3) step();
    end
    mode = 1'b0;

    // Two simultaneous edges: one served, one queued, back-to-back windows
    rvvi = 1'b0;
    pulse(2'b11);
    check("both_pend", pend, 1);
    rvvi = 1'b1;
    measure(len, low, 1'b0);
    check("both_len1", len, BASE);
    check("both_pend_gap", pend, 1);
    measure(len, low, 1'b0);
    check("both_gap", low, GAP + 2);
    check("both_len2", len, BASE);
    check("both_pend_end", pend, 0);
    repeat (GAP + 3) step();

    // Three edges during HOLD, then three further windows
    pulse(2'b01);
    repeat (3) pulse(2'b01);
    check("hold3_pend", pend, 3);
    check("hold3_ovf", ovf, 0);
    measure(len, low, 1'b0);
    for (int k = 0; k < 3; k++) begin
      measure(len, low, 1'b0);
      check($sformatf("hold3_gap%0d", k), low, GAP + 2);
      check($sformatf("hold3_len%0d", k), len, BASE);
      check($sformatf("hold3_pend%0d", k), pend, 2 - k);
    end
    repeat (GAP + 3) step();
    check("hold3_drained", pend, 0);

    // Random edge bursts during HOLD against a saturating count
    for (int t = 0; t < 4; t++) begin
      do_reset();
      total = 0;
      pulse(2'b01);
      n = $urandom_range(1, 4);
      for (int p = 0; p < n; p++) begin
        m = 2'($urandom_range(1, 3));
        total += int'(m[0]) + int'(m[1]);
        pulse(m);
      end
      check($sformatf("rand_pend%0d", t), pend, (total > PMAX) ? PMAX : total);
      check($sformatf("rand_ovf%0d", t), ovf, total > PMAX);
      repeat (4 * (BASE + GAP + 3) + 10) step();
      check($sformatf("rand_drain%0d", t), pend, 0);
    end

    // Six edges saturate the pending count; overflow is sticky
    do_reset();
    pulse(2'b01);
    check("sat_ovf_before", ovf, 0);
    repeat (3) pulse(2'b11);
    check("sat_pend", pend, PMAX);
    check("sat_ovf", ovf, 1);
    repeat (4 * (BASE + GAP + 3) + 10) step();
    check("sat_drain", pend, 0);
    check("sat_ovf_sticky", ovf, 1);

    // Reset mid-HOLD drops HostStall at once and leaves the FSM idle
    pulse(2'b01);
    repeat (5) step();
    check("abort_in_hold", host_stall, 1);
    #2 resetn = 1'b0;
    #1;
    check("abort_stall", host_stall, 0);
    check("abort_pend", pend, 0);
    check("abort_ovf", ovf, 0);
    step();
    resetn = 1'b1;
    rose = 1'b0;
    repeat (40) begin if (host_stall) rose = 1'b1; step(); end
    check("abort_idle", rose, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
